mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (data load/store).
- Fixed priority: the data side wins, because the MEM stage holds the older instruction.
- Registers each granted request, drives the memory handshake, and returns data and a one-cycle ack to the owner.
- Emits per-side stall signals for the hazard/PC-stall logic, plus a watchdog that aborts hung accesses.

---
 rtl/mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency memory between the instruction
// fetch side (IF) and the data load/store side (DM). DM has fixed priority
// because the MEM stage holds the older instruction. A granted request is
// registered onto the mem_* port, held until mem_ack_i, and the result is
// returned to its owner with a one-cycle ack. A watchdog aborts accesses the
// memory never acknowledges.
//
// Handshake semantics (all three ports): a requester raises req and holds it,
// with its address/data stable, until it sees its one-cycle ack. During the
// ack cycle it must drop or replace the request before the next edge; the
// arbiter never samples requests in that cycle. mem_req_o follows the same
// rule towards the memory: held with stable mem_* until mem_ack_i, and there
// is never more than one memory request outstanding.
//
// Parameters:
//   ADDR_W   address width of all address ports
//   DATA_W   data width of all data ports
//   TIMEOUT  wait cycles in an access state before abort (0 = no watchdog)
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   if_req_i / if_addr_i       fetch request and address
//   if_data_o / if_ack_o       fetched word, valid with the one-cycle ack
//   if_stall_o                 if_req_i & ~if_ack_o
//   dm_req_i / dm_we_i         data request, 1 = store
//   dm_addr_i / dm_wdata_i     data address and store data
//   dm_rdata_o / dm_ack_o      load data, valid with the one-cycle ack
//   dm_stall_o                 dm_req_i & ~dm_ack_o
//   mem_req_o .. mem_wdata_o   memory request port (registered)
//   mem_rdata_i / mem_ack_i    memory response
//   err_o                      pulse with the ack when the access timed out
//   dbg_state_o                current FSM state (IDLE=0, IF_ACC=1,
//                              DM_ACC=2, DONE=3)
//
// Optional feature (macro MEM_ARB_PERF_CNT_EN):
//   if_wait_cnt_o / dm_wait_cnt_o  saturating counts of stall cycles per side
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       dm_wait_cnt_o,
`endif
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The watchdog counts 0 .. TIMEOUT-1; the abort fires in the access cycle
    // where the count sits at TIMEOUT-1 with no ack, so mem_req_o stays high
    // for exactly TIMEOUT cycles.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_t          state_q;
    state_t          state_d;
    logic [WD_W-1:0] wd_cnt_q;
    logic            owner_dm_q;   // owner of the current/last access: 1 = DM
    logic            err_q;        // last access ended by the watchdog
    logic            timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dm_req_i) begin
                    state_d = DM_ACC;
                end else if (if_req_i) begin
                    state_d = IF_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ack_i || timeout_hit) begin
                    state_d = DONE;
                end
            end
            // Requests are deliberately not looked at here: the owner is
            // still seeing its ack and may be swapping in a new request.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        mem_req_o = 1'b0;
        if_ack_o  = 1'b0;
        dm_ack_o  = 1'b0;
        err_o     = 1'b0;
        case (state_q)
            IF_ACC, DM_ACC: mem_req_o = 1'b1;
            DONE: begin
                if_ack_o = ~owner_dm_q;
                dm_ack_o = owner_dm_q;
                err_o    = err_q;
            end
            default: ;
        endcase
    end

    assign if_stall_o  = if_req_i & ~if_ack_o;
    assign dm_stall_o  = dm_req_i & ~dm_ack_o;
    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q    <= '0;
            owner_dm_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_cnt_q <= '0;
                    if (dm_req_i) begin
                        owner_dm_q  <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (if_req_i) begin
                        owner_dm_q <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
                end
                IF_ACC, DM_ACC: begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    if (mem_ack_i) begin
                        // Stores also return mem_rdata_i; MEM ignores it.
                        err_q <= 1'b0;
                        if (owner_dm_q) begin
                            dm_rdata_o <= mem_rdata_i;
                        end else begin
                            if_data_o <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (owner_dm_q) begin
                            dm_rdata_o <= '0;
                        end else begin
                            if_data_o <= '0;
                        end
                    end
                end
                default: wd_cnt_q <= '0;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // ---------------------------------------------------------------- perf
    logic [31:0] if_wait_cnt_q;
    logic [31:0] dm_wait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_wait_cnt_q <= '0;
            dm_wait_cnt_q <= '0;
        end else begin
            if (if_stall_o && (if_wait_cnt_q != 32'hFFFF_FFFF)) begin
                if_wait_cnt_q <= if_wait_cnt_q + 32'd1;
            end
            if (dm_stall_o && (dm_wait_cnt_q != 32'hFFFF_FFFF)) begin
                dm_wait_cnt_q <= dm_wait_cnt_q + 32'd1;
            end
        end
    end

    assign if_wait_cnt_o = if_wait_cnt_q;
    assign dm_wait_cnt_o = dm_wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios with cycle-exact expectations, followed by a randomized
// run against a transaction-level reference: the DM side wins any IDLE-cycle
// collision, an IDLE cycle with a pending request starts an access on the next
// cycle, an access ends one cycle after the memory acks, and every completion
// returns the word the memory delivered to the side that owned the access.
// Cycle c is the interval after the c-th rising edge of a scenario; inputs are
// driven 1 ns after the edge and outputs are checked 2 ns after it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [DATA_W-1:0] if_data;
    logic              if_ack;
    logic              if_stall;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              err;
    logic [1:0]        dbg_state;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]       if_wait_cnt;
    logic [31:0]       dm_wait_cnt;
`endif

    int checks = 0;
    int passed = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_data_o    (if_data),
        .if_ack_o     (if_ack),
        .if_stall_o   (if_stall),
        .dm_req_i     (dm_req),
        .dm_we_i      (dm_we),
        .dm_addr_i    (dm_addr),
        .dm_wdata_i   (dm_wdata),
        .dm_rdata_o   (dm_rdata),
        .dm_ack_o     (dm_ack),
        .dm_stall_o   (dm_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .err_o        (err),
`ifdef MEM_ARB_PERF_CNT_EN
        .if_wait_cnt_o(if_wait_cnt),
        .dm_wait_cnt_o(dm_wait_cnt),
`endif
        .dbg_state_o  (dbg_state)
    );

    // ------------------------------------------------------------ driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++; if ({mem_req, mem_we, if_ack, dm_ack, err} !== 5'b0) $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, if_ack, dm_ack, err}); else passed++;
        checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else passed++;
        checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else passed++;
        checks++; if (if_data !== '0) $display("FAIL reset_if_data got=%h exp=0", if_data); else passed++;
        checks++; if (dm_rdata !== '0) $display("FAIL reset_dm_rdata got=%h exp=0", dm_rdata); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_if_only();
        int run = 0;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h100; end
            if (if_ack) if_req = 1'b0;
            run       = mem_req ? run + 1 : 0;
            mem_ack   = mem_req && (run == 3);
            mem_rdata = mem_ack ? 32'hDEAD_BEEF : $urandom;
            #1;
            checks++; if (mem_req !== (c >= 1 && c <= 3)) $display("FAIL if_only_mem_req c=%0d got=%b", c, mem_req); else passed++;
            if (c >= 1 && c <= 3) begin
                checks++; if ({mem_we, mem_addr} !== {1'b0, 32'h100}) $display("FAIL if_only_mem_port c=%0d got we=%b addr=%h exp we=0 addr=100", c, mem_we, mem_addr); else passed++;
            end
            checks++; if (if_ack !== (c == 4)) $display("FAIL if_only_if_ack c=%0d got=%b", c, if_ack); else passed++;
            if (c == 4) begin
                checks++; if (if_data !== 32'hDEAD_BEEF) $display("FAIL if_only_if_data got=%h exp=deadbeef", if_data); else passed++;
            end
            checks++; if (if_stall !== (c <= 3)) $display("FAIL if_only_if_stall c=%0d got=%b", c, if_stall); else passed++;
            checks++; if ({dm_ack, err} !== 2'b00) $display("FAIL if_only_dm_ack_err c=%0d got=%b exp=00", c, {dm_ack, err}); else passed++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_collision();
        int run = 0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h200;
                dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
            end
            if (if_ack) if_req = 1'b0;
            if (dm_ack) begin dm_req = 1'b0; dm_we = 1'b0; end
            run       = mem_req ? run + 1 : 0;
            mem_ack   = mem_req && (run == 2);
            mem_rdata = mem_ack ? ((c < 4) ? 32'hA5A5_0001 : 32'hC0DE_0002) : $urandom;
            #1;
            checks++; if (mem_req !== (c inside {1, 2, 5, 6})) $display("FAIL collision_mem_req c=%0d got=%b", c, mem_req); else passed++;
            if (c inside {1, 2}) begin
                checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, 32'h1234_5678}) $display("FAIL collision_dm_port c=%0d got we=%b addr=%h wdata=%h exp we=1 addr=40 wdata=12345678", c, mem_we, mem_addr, mem_wdata); else passed++;
            end
            if (c inside {5, 6}) begin
                checks++; if ({mem_we, mem_addr} !== {1'b0, 32'h200}) $display("FAIL collision_if_port c=%0d got we=%b addr=%h exp we=0 addr=200", c, mem_we, mem_addr); else passed++;
            end
            checks++; if (dm_ack !== (c == 3)) $display("FAIL collision_dm_ack c=%0d got=%b", c, dm_ack); else passed++;
            checks++; if (if_ack !== (c == 7)) $display("FAIL collision_if_ack c=%0d got=%b", c, if_ack); else passed++;
            if (c == 7) begin
                checks++; if (if_data !== 32'hC0DE_0002) $display("FAIL collision_if_data got=%h exp=c0de0002", if_data); else passed++;
            end
            checks++; if (if_stall !== (c <= 6)) $display("FAIL collision_if_stall c=%0d got=%b", c, if_stall); else passed++;
            checks++; if (dm_stall !== (c <= 2)) $display("FAIL collision_dm_stall c=%0d got=%b", c, dm_stall); else passed++;
        end
`ifdef MEM_ARB_PERF_CNT_EN
        checks++; if (dm_wait_cnt !== 32'd3) $display("FAIL collision_dm_wait_cnt got=%0d exp=3", dm_wait_cnt); else passed++;
        checks++; if (if_wait_cnt !== 32'd7) $display("FAIL collision_if_wait_cnt got=%0d exp=7", if_wait_cnt); else passed++;
`endif
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int run  = 0;
        int nack = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; end
            if (dm_ack) begin
                nack++;
                // first ack: replace the request right away; second: drop it
                if (nack == 1) dm_addr = 32'h304; else dm_req = 1'b0;
            end
            run       = mem_req ? run + 1 : 0;
            mem_ack   = mem_req && (run == 1);
            mem_rdata = mem_ack ? ((nack == 0) ? 32'h1111_0000 : 32'h2222_0000) : $urandom;
            #1;
            checks++; if (mem_req !== (c inside {1, 4})) $display("FAIL b2b_mem_req c=%0d got=%b", c, mem_req); else passed++;
            if (c == 1 || c == 4) begin
                checks++; if (mem_addr !== ((c == 1) ? 32'h300 : 32'h304)) $display("FAIL b2b_mem_addr c=%0d got=%h", c, mem_addr); else passed++;
            end
            checks++; if (dm_ack !== (c inside {2, 5})) $display("FAIL b2b_dm_ack c=%0d got=%b", c, dm_ack); else passed++;
            if (c == 2 || c == 3) begin
                checks++; if (dm_rdata !== 32'h1111_0000) $display("FAIL b2b_dm_rdata1 c=%0d got=%h exp=11110000", c, dm_rdata); else passed++;
            end
            if (c == 5) begin
                checks++; if (dm_rdata !== 32'h2222_0000) $display("FAIL b2b_dm_rdata2 got=%h exp=22220000", dm_rdata); else passed++;
            end
            checks++; if (dm_stall !== (c inside {0, 1, 3, 4})) $display("FAIL b2b_dm_stall c=%0d got=%b", c, dm_stall); else passed++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (c == 0) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; end
            if (dm_ack) dm_req = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            #1;
            checks++; if (mem_req !== (c >= 1 && c <= TIMEOUT)) $display("FAIL timeout_mem_req c=%0d got=%b", c, mem_req); else passed++;
            checks++; if (dm_ack !== (c == TIMEOUT + 1)) $display("FAIL timeout_dm_ack c=%0d got=%b", c, dm_ack); else passed++;
            checks++; if (err !== (c == TIMEOUT + 1)) $display("FAIL timeout_err c=%0d got=%b", c, err); else passed++;
            if (c == TIMEOUT + 1) begin
                checks++; if (dm_rdata !== '0) $display("FAIL timeout_dm_rdata got=%h exp=0", dm_rdata); else passed++;
            end
            checks++; if (dm_stall !== (c <= TIMEOUT)) $display("FAIL timeout_dm_stall c=%0d got=%b", c, dm_stall); else passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h600; end
            if (c == 2) rst = 1'b1;
            if (c == 3) begin rst = 1'b0; if_req = 1'b0; end
            if (c == 5) begin if_req = 1'b1; if_addr = 32'h604; end
            if (if_ack) if_req = 1'b0;
            mem_ack   = (c == 3) || (mem_req && c == 6);
            mem_rdata = (c == 3) ? 32'hFFFF_FFFF : ((c == 6) ? 32'h7777_0000 : $urandom);
            #1;
            checks++; if (mem_req !== (c inside {1, 2, 6})) $display("FAIL rstmid_mem_req c=%0d got=%b", c, mem_req); else passed++;
            checks++; if (if_ack !== (c == 7)) $display("FAIL rstmid_if_ack c=%0d got=%b", c, if_ack); else passed++;
            checks++; if ({dm_ack, err} !== 2'b00) $display("FAIL rstmid_dm_ack_err c=%0d got=%b exp=00", c, {dm_ack, err}); else passed++;
            if (c == 3 || c == 4) begin
                checks++; if ({mem_we, mem_addr, mem_wdata, if_data, dm_rdata, dbg_state} !== '0) $display("FAIL rstmid_outputs_zero c=%0d got we=%b addr=%h wdata=%h if_data=%h dm_rdata=%h state=%0d", c, mem_we, mem_addr, mem_wdata, if_data, dm_rdata, dbg_state); else passed++;
            end
            if (c == 6) begin
                checks++; if (mem_addr !== 32'h604) $display("FAIL rstmid_mem_addr got=%h exp=604", mem_addr); else passed++;
            end
            if (c == 7) begin
                checks++; if (if_data !== 32'h7777_0000) $display("FAIL rstmid_if_data got=%h exp=77770000", if_data); else passed++;
            end
            checks++; if (if_stall !== (c inside {0, 1, 2, 5, 6})) $display("FAIL rstmid_if_stall c=%0d got=%b", c, if_stall); else passed++;
        end
        mem_ack = 1'b0;
    endtask

    // Randomized traffic with a scoreboard: exp_q holds {owner_is_dm, data}
    // for every completion the memory has produced but the DUT not yet acked.
    task automatic test_random();
        logic [DATA_W:0]   exp_q[$];
        logic [DATA_W:0]   got;
        logic [DATA_W:0]   e;
        logic              ack_due      = 1'b0;
        logic              prev_mem_req = 1'b0;
        logic              prev_mem_ack = 1'b0;
        logic              prev_ack     = 1'b0;
        logic              prev_if_req  = 1'b0;
        logic [ADDR_W-1:0] prev_if_addr = '0;
        logic              prev_dm_req  = 1'b0;
        logic              prev_dm_we   = 1'b0;
        logic [ADDR_W-1:0] prev_dm_addr = '0;
        logic [DATA_W-1:0] prev_dm_wdata = '0;
        logic              cur_dm = 1'b0;
        logic              cur_we = 1'b0;
        logic [ADDR_W-1:0] cur_addr = '0;
        logic [DATA_W-1:0] cur_wdata = '0;
        logic              exp_mem_req;
        logic              quiesce;
        int run = 0;
        int lat = 1;
        int if_wait = 0;
        int dm_wait = 0;
        int max_wait = 0;
        for (int cyc = 0; cyc < 540; cyc++) begin
            next_cycle();
            quiesce = (cyc >= 500);
            // completions: exactly one cycle after the memory ack
            checks++; if ((if_ack | dm_ack) !== ack_due) $display("FAIL rand_ack_timing cyc=%0d got=%b exp=%b", cyc, if_ack | dm_ack, ack_due); else passed++;
            if (if_ack | dm_ack) begin
                got = {dm_ack, dm_ack ? dm_rdata : if_data};
                e   = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {DATA_W{1'bx}}};
                checks++; if (got !== e || (if_ack && dm_ack)) $display("FAIL rand_completion cyc=%0d got owner_dm=%b data=%h exp owner_dm=%b data=%h", cyc, got[DATA_W], got[DATA_W-1:0], e[DATA_W], e[DATA_W-1:0]); else passed++;
            end
            ack_due = 1'b0;
            checks++; if (err !== 1'b0) $display("FAIL rand_err cyc=%0d got=1 exp=0", cyc); else passed++;
            // memory request: held until acked; otherwise starts one cycle
            // after an IDLE cycle that saw a request, never right after an ack
            exp_mem_req = prev_mem_req ? ~prev_mem_ack : (~prev_ack & (prev_if_req | prev_dm_req));
            checks++; if (mem_req !== exp_mem_req) $display("FAIL rand_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_mem_req); else passed++;
            if (mem_req && !prev_mem_req) begin
                // new access: DM wins whenever it was requesting
                cur_dm    = prev_dm_req;
                cur_we    = prev_dm_req ? prev_dm_we : 1'b0;
                cur_addr  = prev_dm_req ? prev_dm_addr : prev_if_addr;
                cur_wdata = prev_dm_wdata;
                lat       = $urandom_range(1, TIMEOUT - 1);
                run       = 0;
            end
            if (mem_req) begin
                checks++; if (mem_we !== cur_we || mem_addr !== cur_addr || (cur_we && mem_wdata !== cur_wdata)) $display("FAIL rand_mem_port cyc=%0d got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h", cyc, mem_we, mem_addr, mem_wdata, cur_we, cur_addr, cur_wdata); else passed++;
            end
            // memory model
            run       = mem_req ? run + 1 : 0;
            mem_ack   = mem_req && (run == lat);
            mem_rdata = $urandom;
            if (mem_ack) begin
                exp_q.push_back({cur_dm, mem_rdata});
                ack_due = 1'b1;
            end
            // requesters
            if (if_ack) begin
                if_req = !quiesce && ($urandom_range(0, 1) == 1);
                if_addr = $urandom;
            end else if (!if_req && !quiesce && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            if (dm_ack) begin
                dm_req = !quiesce && ($urandom_range(0, 1) == 1);
                dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
            end else if (!dm_req && !quiesce && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1;
                dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
            end
            #1;
            checks++; if (if_stall !== (if_req & ~if_ack)) $display("FAIL rand_if_stall cyc=%0d got=%b", cyc, if_stall); else passed++;
            checks++; if (dm_stall !== (dm_req & ~dm_ack)) $display("FAIL rand_dm_stall cyc=%0d got=%b", cyc, dm_stall); else passed++;
            if_wait  = if_req ? if_wait + 1 : 0;
            dm_wait  = dm_req ? dm_wait + 1 : 0;
            max_wait = (if_wait > max_wait) ? if_wait : max_wait;
            max_wait = (dm_wait > max_wait) ? dm_wait : max_wait;
            prev_mem_req  = mem_req;
            prev_mem_ack  = mem_ack;
            prev_ack      = if_ack | dm_ack;
            prev_if_req   = if_req;
            prev_if_addr  = if_addr;
            prev_dm_req   = dm_req;
            prev_dm_we    = dm_we;
            prev_dm_addr  = dm_addr;
            prev_dm_wdata = dm_wdata;
        end
        checks++; if (exp_q.size() != 0 || ack_due) $display("FAIL rand_drain got pending=%0d exp=0", exp_q.size() + int'(ack_due)); else passed++;
        checks++; if ({if_req, dm_req, mem_req} !== 3'b000) $display("FAIL rand_all_served got if_req=%b dm_req=%b mem_req=%b exp 000", if_req, dm_req, mem_req); else passed++;
        checks++; if (max_wait > 200) $display("FAIL rand_max_wait got=%0d limit=200", max_wait); else passed++;
        mem_ack = 1'b0;
    endtask

    // ------------------------------------------------------------ main
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_if_only();
        test_collision();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached before the end of the scenarios");
        $fatal(1);
    end

endmodule
